// File: rtl/fifo_pkg.sv
// Shared constants and sizing helpers for the threshold FIFO.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 3;

    // Number of words addressed by a pointer of the given width.
    function automatic int fifo_depth(input int addr_width);
        return 32'sd1 << addr_width;
    endfunction

    // Occupancy counter width: one extra bit so DEPTH itself is representable.
    function automatic int fifo_cnt_width(input int addr_width);
        return addr_width + 32'sd1;
    endfunction

endpackage

// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and status-flag control for fifo_thresh.
// Optional sticky overflow/underflow flags are built only when FIFO_ERR_EN is defined.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int AF_LEVEL   = fifo_depth(DEF_ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clr,
    input  logic                  wr,
    input  logic                  rd,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int CW = fifo_cnt_width(ADDR_WIDTH);
    localparam logic [CW-1:0]         DEPTH_C  = CW'(fifo_depth(ADDR_WIDTH));
    localparam logic [CW-1:0]         AF_C     = CW'(AF_LEVEL);
    localparam logic [CW-1:0]         AE_C     = CW'(AE_LEVEL);
    localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]         CNT_ZERO = CW'(0);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ZERO = ADDR_WIDTH'(0);

    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [CW-1:0]         count_r;
    logic [ADDR_WIDTH-1:0] wr_ptr_nxt_s;
    logic [ADDR_WIDTH-1:0] rd_ptr_nxt_s;
    logic [CW-1:0]         count_nxt_s;
    logic                  full_s;
    logic                  empty_s;
    logic                  wr_ok_s;
    logic                  rd_ok_s;

    // Flags come only from the registered count, never from the requests.
    assign full_s  = (count_r == DEPTH_C);
    assign empty_s = (count_r == CNT_ZERO);

    // A write into a full FIFO is allowed when a read frees a slot on the same edge;
    // a read of an empty FIFO is never accepted, so wr=rd=1 on empty is a plain write.
    assign wr_ok_s = wr && (!full_s || rd);
    assign rd_ok_s = rd && !empty_s;

    // Next pointers and occupancy; flush overrides any request in the same cycle.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        if (clr) begin
            wr_ptr_nxt_s = PTR_ZERO;
            rd_ptr_nxt_s = PTR_ZERO;
            count_nxt_s  = CNT_ZERO;
        end else begin
            if (wr_ok_s) begin
                wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (rd_ok_s) begin
                rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            case ({wr_ok_s, rd_ok_s})
                2'b10:   count_nxt_s = count_r + CNT_ONE;
                2'b01:   count_nxt_s = count_r - CNT_ONE;
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Pointer and occupancy state; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
        end
    end

`ifdef FIFO_ERR_EN
    logic overflow_r;
    logic underflow_r;

    // Sticky error flags: set on a rejected push or an empty pop, cleared only by reset or flush.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (clr) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr && full_s && !rd) begin
                overflow_r <= 1'b1;
            end
            if (rd && empty_s) begin
                underflow_r <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_r;
    assign underflow = underflow_r;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    assign wr_en        = wr_ok_s && !clr;
    assign wr_addr      = wr_ptr_r;
    assign rd_addr      = rd_ptr_r;
    assign count        = count_r;
    assign full         = full_s;
    assign empty        = empty_s;
    assign almost_full  = (count_r >= AF_C);
    assign almost_empty = (count_r <= AE_C);

endmodule

// File: rtl/fifo_thresh.sv
// Synchronous show-ahead FIFO with almost-full/almost-empty thresholds.
// Define FIFO_ERR_EN to build the sticky overflow/underflow flags.
module fifo_thresh
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int AF_LEVEL   = fifo_depth(ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clr,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    // Thresholds must be ordered and reachable.
    if ((AE_LEVEL >= AF_LEVEL) || (AF_LEVEL > DEPTH)) begin : g_bad_params
        $error("fifo_thresh: need AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic                  wr_en_s;
    logic [ADDR_WIDTH-1:0] wr_addr_s;
    logic [ADDR_WIDTH-1:0] rd_addr_s;

    fifo_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .AF_LEVEL   (AF_LEVEL),
        .AE_LEVEL   (AE_LEVEL)
    ) u_ctrl (
        .clk          (clk),
        .reset_n      (reset_n),
        .clr          (clr),
        .wr           (wr),
        .rd           (rd),
        .wr_en        (wr_en_s),
        .wr_addr      (wr_addr_s),
        .rd_addr      (rd_addr_s),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // Storage array write port; contents deliberately survive reset and flush.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_addr_s] <= w_data;
        end
    end

    // Show-ahead: the head word is visible without a read request.
    assign r_data = mem_r[rd_addr_s];

endmodule

// File: tb/tb_fifo_thresh.sv
// Self-checking bench for fifo_thresh against a queue-based reference model.
module tb_fifo_thresh;

`ifdef FIFO_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       clr = 1'b0;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic [7:0] w_data = 8'h00;
    logic [7:0] r_data;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0] count;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_q[$];
    bit         m_ovf = 1'b0;
    bit         m_unf = 1'b0;

    fifo_thresh #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (3),
        .AF_LEVEL   (6),
        .AE_LEVEL   (1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clr          (clr),
        .wr           (wr),
        .w_data       (w_data),
        .rd           (rd),
        .r_data       (r_data),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    // Expected {full, empty, almost_full, almost_empty} from model occupancy.
    function automatic logic [3:0] exp_flags();
        int n = m_q.size();
        return {n == 8, n == 0, n >= 6, n <= 1};
    endfunction

    function automatic logic exp_ovf();
        return ERR_EN ? m_ovf : 1'b0;
    endfunction

    function automatic logic exp_unf();
        return ERR_EN ? m_unf : 1'b0;
    endfunction

    // One clock of stimulus; model follows the FIFO rules on the same edge.
    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
        bit was_full, was_empty;
        @(negedge clk);
        wr = w; w_data = d; rd = r; clr = c;
        @(posedge clk);
        was_full  = (m_q.size() == 8);
        was_empty = (m_q.size() == 0);
        if (c) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (w && was_full && !r) m_ovf = 1'b1;
            if (r && was_empty) m_unf = 1'b1;
            if (r && !was_empty) void'(m_q.pop_front());
            if (w && (!was_full || r)) m_q.push_back(d);
        end
        #1;
        wr = 1'b0; rd = 1'b0; clr = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({full, empty, almost_full, almost_empty} !== 4'b0101) begin
            errors++; $display("FAIL reset_flags got %b want 0101", {full, empty, almost_full, almost_empty});
        end
        checks++;
        if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++;
        if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_err got %b want 00", {overflow, underflow}); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            checks++;
            if (count !== 4'(i)) begin errors++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i); end
            checks++;
            if ({full, empty, almost_full, almost_empty} !== exp_flags()) begin
                errors++; $display("FAIL fill_flags[%0d] got %b want %b", i, {full, empty, almost_full, almost_empty}, exp_flags());
            end
        end
        for (int i = 1; i <= 8; i++) begin
            checks++;
            if (r_data !== 8'(i)) begin errors++; $display("FAIL drain_data[%0d] got %h want %h", i, r_data, 8'(i)); end
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        checks++;
        if ({full, empty, count} !== {2'b01, 4'd0}) begin
            errors++; $display("FAIL drain_end got full=%b empty=%b count=%0d want 0 1 0", full, empty, count);
        end
    endtask

    task automatic test_full_both();
        while (m_q.size() < 8) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        checks++;
        if ({full, count} !== {1'b1, 4'd8}) begin errors++; $display("FAIL fb_state got full=%b count=%0d want 1 8", full, count); end
        checks++;
        if (r_data !== m_q[0]) begin errors++; $display("FAIL fb_head got %h want %h", r_data, m_q[0]); end
        while (m_q.size() > 0) begin
            checks++;
            if (r_data !== m_q[0]) begin errors++; $display("FAIL fb_drain got %h want %h", r_data, m_q[0]); end
            if (m_q.size() == 1) begin
                checks++;
                if (r_data !== 8'hA5) begin errors++; $display("FAIL fb_last got %h want a5", r_data); end
            end
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
    endtask

    task automatic test_empty_both();
        step(1'b1, 8'h3C, 1'b1, 1'b0);
        checks++;
        if ({empty, count} !== {1'b0, 4'd1}) begin errors++; $display("FAIL eb_count got empty=%b count=%0d want 0 1", empty, count); end
        checks++;
        if (r_data !== 8'h3C) begin errors++; $display("FAIL eb_data got %h want 3c", r_data); end
        checks++;
        if (underflow !== exp_unf()) begin errors++; $display("FAIL eb_underflow got %b want %b", underflow, exp_unf()); end
        step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_wrap();
        bit w, r;
        for (int i = 0; i < 20; i++) begin
            w = ($urandom_range(0, 99) < 65);
            r = ($urandom_range(0, 99) < 45);
            if (r && m_q.size() > 0) begin
                checks++;
                if (r_data !== m_q[0]) begin errors++; $display("FAIL wrap_data[%0d] got %h want %h", i, r_data, m_q[0]); end
            end
            step(w, 8'($urandom), r, 1'b0);
            checks++;
            if (count !== 4'(m_q.size())) begin errors++; $display("FAIL wrap_count[%0d] got %0d want %0d", i, count, m_q.size()); end
            checks++;
            if ({full, empty, almost_full, almost_empty, overflow, underflow} !== {exp_flags(), exp_ovf(), exp_unf()}) begin
                errors++; $display("FAIL wrap_flags[%0d] got %b want %b", i,
                    {full, empty, almost_full, almost_empty, overflow, underflow}, {exp_flags(), exp_ovf(), exp_unf()});
            end
        end
        while (m_q.size() > 0) begin
            checks++;
            if (r_data !== m_q[0]) begin errors++; $display("FAIL wrap_drain got %h want %h", r_data, m_q[0]); end
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
    endtask

    task automatic test_overflow_clr();
        logic [7:0] head;
        while (m_q.size() < 8) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        head = m_q[0];
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        checks++;
        if ({full, count} !== {1'b1, 4'd8}) begin errors++; $display("FAIL ovf_count got full=%b count=%0d want 1 8", full, count); end
        checks++;
        if (r_data !== head) begin errors++; $display("FAIL ovf_head got %h want %h", r_data, head); end
        checks++;
        if (overflow !== exp_ovf()) begin errors++; $display("FAIL ovf_flag got %b want %b", overflow, exp_ovf()); end
        step(1'b1, 8'h77, 1'b1, 1'b1);
        checks++;
        if ({empty, count, overflow, underflow} !== {1'b1, 4'd0, 2'b00}) begin
            errors++; $display("FAIL clr_state got empty=%b count=%0d ovf=%b unf=%b want 1 0 0 0", empty, count, overflow, underflow);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] d;
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        wr = 1'b1; w_data = 8'h99;
        #2;
        reset_n = 1'b0;
        wr = 1'b0;
        m_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        #1;
        checks++;
        if ({full, empty, almost_full, almost_empty, count} !== {4'b0101, 4'd0}) begin
            errors++; $display("FAIL async_rst got flags=%b count=%0d want 0101 0", {full, empty, almost_full, almost_empty}, count);
        end
        #3;
        reset_n = 1'b1;
        d = 8'($urandom);
        step(1'b1, d, 1'b0, 1'b0);
        checks++;
        if ({count, r_data} !== {4'd1, d}) begin errors++; $display("FAIL post_rst got count=%0d data=%h want 1 %h", count, r_data, d); end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL post_rst_empty got %b want 1", empty); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_full_both();
        test_empty_both();
        test_wrap();
        test_overflow_clr();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_thresh.md
FIFO_THRESH -- requirements
Module: fifo_thresh

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 3, pointer width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-2, the almost-full threshold in words.
REQ-004 The block SHALL have parameter AE_LEVEL, default 1, the almost-empty threshold in words.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-006 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port clr, input, 1, synchronous flush.
REQ-008 The block SHALL have port wr, input, 1, write request.
REQ-009 The block SHALL have port w_data, input, DATA_WIDTH, write word.
REQ-010 The block SHALL have port rd, input, 1, read/pop request.
REQ-011 The block SHALL have port r_data, output, DATA_WIDTH, head word.
REQ-012 The block SHALL have ports full, empty, almost_full and almost_empty, each output, 1, status flags.
REQ-013 The block SHALL have port count, output, ADDR_WIDTH+1, current occupancy, 0..DEPTH.
REQ-014 The block SHALL have ports overflow and underflow, each output, 1, sticky error flags.

Function
REQ-015 r_data SHALL present the word at the read pointer combinationally (show-ahead); it is valid whenever empty=0, and undefined-but-stable when empty=1.
REQ-016 A write SHALL be accepted when wr=1 and (full=0 or rd=1); the word is stored at the write pointer and the pointer advances by 1 modulo DEPTH.
REQ-017 A read SHALL be accepted when rd=1 and empty=0; the read pointer advances by 1 modulo DEPTH.
REQ-018 When empty=1 and wr=rd=1, only the write SHALL occur; count becomes 1.
REQ-019 When full=1 and wr=rd=1, both SHALL occur; count stays DEPTH and full stays 1.
REQ-020 count SHALL be +1 on write-only, -1 on read-only, and unchanged on both or neither; it SHALL never exceed DEPTH or go below 0.
REQ-021 full SHALL equal (count==DEPTH); empty SHALL equal (count==0); almost_full SHALL equal (count>=AF_LEVEL); almost_empty SHALL equal (count<=AE_LEVEL); all flags SHALL be derived from registered count only.
REQ-022 Pointer wrap from DEPTH-1 to 0 SHALL be seamless, with no lost or duplicated word.
REQ-023 clr=1 SHALL take priority over wr/rd in the same cycle and zero the pointers, count and error flags on the next edge; memory contents are not cleared.
REQ-024 Flags SHALL update in the same edge as count: one-cycle visibility after the request.

Reset
REQ-025 reset_n=0 SHALL asynchronously zero both pointers, count, overflow and underflow, giving empty=1, almost_empty=1, full=0 and almost_full=0.
REQ-026 Reset asserted mid-operation SHALL abort any in-flight request; the first accepted write after deassertion lands at address 0.
REQ-027 The storage array SHALL not be reset.

Configuration
REQ-028 With macro FIFO_ERR_EN defined, overflow SHALL set on wr=1 with full=1 and rd=0, underflow SHALL set on rd=1 with empty=1, and both SHALL hold until reset or clr.
REQ-029 Without FIFO_ERR_EN, overflow and underflow SHALL be tied to 0, with no flop inferred; all other behaviour is identical.

Structure
REQ-030 A shared package fifo_pkg SHALL hold the default DATA_WIDTH and ADDR_WIDTH constants and a depth/count-width helper function.
REQ-031 Pointer, count and flag logic SHALL live in the sub-module fifo_ctrl; the top-level block holds the register file and instantiates fifo_ctrl.
REQ-032 A parameter check SHALL flag AE_LEVEL >= AF_LEVEL or AF_LEVEL > DEPTH as an elaboration error.

Verification (DATA_WIDTH=8, ADDR_WIDTH=3, AF_LEVEL=6, AE_LEVEL=1)
REQ-033 Reset release, then writes 0x01..0x08 -> count 1..8; almost_empty drops after the 2nd write; almost_full rises after the 6th; full=1 after the 8th; then reads return 0x01..0x08 in order and empty=1.
REQ-034 Fill to 8, then wr=rd=1 with w_data=0xA5 -> r_data advances, count stays 8, full stays 1, and 0xA5 is read last.
REQ-035 Empty FIFO, wr=rd=1 with w_data=0x3C -> count=1 and r_data=0x3C next cycle; with FIFO_ERR_EN, underflow=1.
REQ-036 Run 20 mixed write/read cycles crossing the address-7-to-0 wrap -> read sequence equals write sequence; count matches a scoreboard.
REQ-037 Full FIFO, wr=1 with rd=0 -> count stays 8 and contents are unchanged; overflow=1 with FIFO_ERR_EN and 0 without; then clr=1 -> count=0, empty=1, overflow=0.
REQ-038 reset_n pulsed low mid-burst at count=5, asynchronously to clk -> flags reach reset values immediately; next write followed by a read returns that word.
